// File: rtl/dco_code_recovery_if.sv
// Bus bundle for the DCO code recovery block: control/stimulus in, measurement out.
interface dco_code_recovery_if;
    logic       ena;
    logic       clear;
    logic       sig_in;
    logic [7:0] half_period;
    logic       meas_strobe;
    logic [7:0] code_out;
    logic       code_valid;
    logic       code_err;
    logic       locked;
    logic       lost;

    // Driver side (tile logic or bench).
    modport master (
        output ena,
        output clear,
        output sig_in,
        input  half_period,
        input  meas_strobe,
        input  code_out,
        input  code_valid,
        input  code_err,
        input  locked,
        input  lost
    );

    // Recovery block side.
    modport slave (
        input  ena,
        input  clear,
        input  sig_in,
        output half_period,
        output meas_strobe,
        output code_out,
        output code_valid,
        output code_err,
        output locked,
        output lost
    );
endinterface

// File: rtl/dco_code_recovery.sv
// Receive side of the DCO link: measures the half-period of an incoming DCO square
// wave in clk cycles, locks onto a stable interval and decodes it into the one-hot
// DCO control code.
module dco_code_recovery #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT     = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dco_code_recovery_if.slave   bus
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    localparam logic [3:0] LockCnt    = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StTrack,
        StLocked
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_prev_q;
    logic                   sig_edge;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic [3:0] match_q, match_d;
    logic [3:0] match_inc;
    logic [7:0] half_period_q, half_period_d;
    logic       meas_strobe_q, meas_strobe_d;
    logic [7:0] code_out_q, code_out_d;
    logic       code_valid_q, code_valid_d;
    logic       code_err_q, code_err_d;
    logic       locked_q, locked_d;
    logic       lost_q, lost_d;
    logic       timeout_hit;
    logic [7:0] dec_code;
    logic       dec_hit;

    // Synchroniser and previous-sample flop; keeps running while ena=0 so edges
    // arriving in a hold window are absorbed rather than replayed later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sig_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            sig_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Either polarity of transition counts; masked while disabled.
    assign sig_edge = bus.ena & (sync_q[SYNC_STAGES-1] ^ sig_prev_q);

    // Saturating count; cnt+1 is also the interval that ends on this edge.
    assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // An edge on the cycle the count would hit the limit wins over the timeout.
    assign timeout_hit = (state_q != StIdle) && !sig_edge && (cnt_inc == TimeoutCnt);
    assign match_inc   = (cnt_inc == half_period_q) ? match_q + 4'd1 : 4'd1;

    // Interval-to-code table; 51 cycles is the valid all-zero code.
    always_comb begin
        dec_code = 8'h00;
        dec_hit  = 1'b1;
        case (cnt_inc)
            8'd11:   dec_code = 8'h80;
            8'd10:   dec_code = 8'h40;
            8'd9:    dec_code = 8'h20;
            8'd8:    dec_code = 8'h10;
            8'd7:    dec_code = 8'h08;
            8'd6:    dec_code = 8'h04;
            8'd5:    dec_code = 8'h02;
            8'd4:    dec_code = 8'h01;
            8'd51:   dec_code = 8'h00;
            default: dec_hit  = 1'b0;
        endcase
    end

    // Next-state and registered-output logic; everything holds unless ena=1.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        match_d       = match_q;
        half_period_d = half_period_q;
        meas_strobe_d = 1'b0;
        code_out_d    = code_out_q;
        code_valid_d  = code_valid_q;
        code_err_d    = code_err_q;
        locked_d      = locked_q;
        lost_d        = lost_q;

        if (bus.ena) begin
            cnt_d = sig_edge ? 8'd0 : cnt_inc;

            if (bus.clear) begin
                state_d      = StIdle;
                lost_d       = 1'b0;
                match_d      = 4'd0;
                locked_d     = 1'b0;
                code_valid_d = 1'b0;
                code_err_d   = 1'b0;
            end else if (timeout_hit) begin
                state_d      = StIdle;
                lost_d       = 1'b1;
                locked_d     = 1'b0;
                code_valid_d = 1'b0;
                code_err_d   = 1'b0;
            end else if (sig_edge) begin
                case (state_q)
                    StIdle: begin
                        // Arming edge: no interval exists yet.
                        state_d = StFirst;
                        lost_d  = 1'b0;
                    end
                    StFirst: begin
                        state_d       = StTrack;
                        half_period_d = cnt_inc;
                        meas_strobe_d = 1'b1;
                        match_d       = 4'd1;
                    end
                    StTrack: begin
                        half_period_d = cnt_inc;
                        meas_strobe_d = 1'b1;
                        match_d       = match_inc;
                        if (match_inc == LockCnt) begin
                            state_d      = StLocked;
                            locked_d     = 1'b1;
                            code_out_d   = dec_code;
                            code_valid_d = dec_hit;
                            code_err_d   = !dec_hit;
                        end
                    end
                    StLocked: begin
                        half_period_d = cnt_inc;
                        meas_strobe_d = 1'b1;
                        if (cnt_inc == half_period_q) begin
                            locked_d     = 1'b1;
                            code_out_d   = dec_code;
                            code_valid_d = dec_hit;
                            code_err_d   = !dec_hit;
                        end else begin
                            state_d      = StTrack;
                            match_d      = 4'd1;
                            locked_d     = 1'b0;
                            code_valid_d = 1'b0;
                            code_err_d   = 1'b0;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            match_q       <= 4'd0;
            half_period_q <= 8'd0;
            meas_strobe_q <= 1'b0;
            code_out_q    <= 8'd0;
            code_valid_q  <= 1'b0;
            code_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            match_q       <= match_d;
            half_period_q <= half_period_d;
            meas_strobe_q <= meas_strobe_d;
            code_out_q    <= code_out_d;
            code_valid_q  <= code_valid_d;
            code_err_q    <= code_err_d;
            locked_q      <= locked_d;
            lost_q        <= lost_d;
        end
    end

    assign bus.half_period = half_period_q;
    assign bus.meas_strobe = meas_strobe_q;
    assign bus.code_out    = code_out_q;
    assign bus.code_valid  = code_valid_q;
    assign bus.code_err    = code_err_q;
    assign bus.locked      = locked_q;
    assign bus.lost        = lost_q;

endmodule

// File: tb/tb_dco_code_recovery.sv
// Bench for dco_code_recovery: toggles sig_in with known spacing, predicts every
// measurement with a behavioural model and checks status flags inline.
module tb_dco_code_recovery;

    localparam int SYNC = 2;
    localparam int LOCKN = 4;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dco_code_recovery_if bus ();

    dco_code_recovery #(
        .SYNC_STAGES (SYNC),
        .LOCK_COUNT  (LOCKN),
        .TIMEOUT     (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hp;
        logic       lk;
        logic [7:0] code;
        logic       vld;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   en_cyc = 0;
    int   last_tog = 0;
    int   strobe_cnt = 0;

    // Model state: 0 idle, 1 first, 2 track, 3 locked.
    int         m_state = 0;
    int         m_match = 0;
    int         m_prev = 0;
    logic [7:0] m_code = 8'h00;
    logic       m_vld = 1'b0;
    logic       m_err = 1'b0;

    // Enabled clock cycles, the time base of the interval counter.
    always @(posedge clk) if (rst_n && bus.ena) en_cyc <= en_cyc + 1;

    function automatic void dec(input int iv, output logic [7:0] c, output logic hit);
        hit = 1'b1;
        case (iv)
            11: c = 8'h80;
            10: c = 8'h40;
            9:  c = 8'h20;
            8:  c = 8'h10;
            7:  c = 8'h08;
            6:  c = 8'h04;
            5:  c = 8'h02;
            4:  c = 8'h01;
            51: c = 8'h00;
            default: begin c = 8'h00; hit = 1'b0; end
        endcase
    endfunction

    function automatic void push(input int iv, input logic lk);
        exp_t e;
        e.hp   = 8'(iv);
        e.lk   = lk;
        e.code = m_code;
        e.vld  = lk ? m_vld : 1'b0;
        e.err  = lk ? m_err : 1'b0;
        sb_q.push_back(e);
    endfunction

    function automatic void lock_code(input int iv);
        logic       hit;
        logic [7:0] c;
        dec(iv, c, hit);
        m_code = c;
        m_vld  = hit;
        m_err  = !hit;
    endfunction

    // Predict the outcome of one sig_in transition separated by gap enabled cycles.
    function automatic void model_edge(input int gap);
        int iv;
        if (m_state != 0 && gap > TMO) m_state = 0;
        iv = (gap > 255) ? 255 : gap;
        case (m_state)
            0: m_state = 1;
            1: begin
                m_state = 2; m_match = 1; m_prev = iv;
                push(iv, 1'b0);
            end
            2: begin
                m_match = (iv == m_prev) ? m_match + 1 : 1;
                m_prev  = iv;
                if (m_match >= LOCKN) begin
                    m_state = 3;
                    lock_code(iv);
                    push(iv, 1'b1);
                end else begin
                    push(iv, 1'b0);
                end
            end
            default: begin
                if (iv == m_prev) begin
                    lock_code(iv);
                    push(iv, 1'b1);
                end else begin
                    m_state = 2; m_match = 1; m_prev = iv;
                    push(iv, 1'b0);
                end
            end
        endcase
    endfunction

    // Scoreboard: every measurement strobe must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (rst_n && bus.meas_strobe) begin
            strobe_cnt++;
            n_total++;
            got = {bus.half_period, bus.locked, bus.code_out, bus.code_valid, bus.code_err};
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_strobe: got hp=%0d lk=%0b code=%h, required no strobe",
                         bus.half_period, bus.locked, bus.code_out);
            end else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL meas: got hp=%0d lk=%0b code=%h v=%0b e=%0b, required hp=%0d lk=%0b code=%h v=%0b e=%0b",
                             got.hp, got.lk, got.code, got.vld, got.err,
                             e.hp, e.lk, e.code, e.vld, e.err);
                else
                    n_pass++;
            end
        end
    end

    // Toggle sig_in n times, period enabled cycles apart, then let the last edge settle.
    task automatic toggle(input int period, input int n);
        for (int i = 0; i < n; i++) begin
            while ((en_cyc - last_tog) < period) begin
                @(posedge clk);
                #1;
            end
            bus.sig_in = ~bus.sig_in;
            model_edge(en_cyc - last_tog);
            last_tog = en_cyc;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_total++;
        if (sb_q.size() != 0)
            $display("FAIL %s_drained: %0d measurements missing, required 0", name, sb_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        bus.ena = 1'b1; bus.clear = 1'b0; bus.sig_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({bus.half_period, bus.meas_strobe, bus.code_out, bus.code_valid, bus.code_err,
             bus.locked, bus.lost} !== 21'd0)
            $display("FAIL reset_outputs: got hp=%0d code=%h lk=%0b lost=%0b, required all 0",
                     bus.half_period, bus.code_out, bus.locked, bus.lost);
        else
            n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock_11();
        strobe_cnt = 0;
        toggle(11, 4);
        n_total++;
        if (bus.locked !== 1'b0) $display("FAIL lock11_early: got locked=%0b, required 0", bus.locked);
        else n_pass++;
        toggle(11, 1);
        n_total++;
        if ({bus.locked, bus.code_out, bus.code_valid, bus.half_period} !== {1'b1, 8'h80, 1'b1, 8'd11})
            $display("FAIL lock11: got lk=%0b code=%h v=%0b hp=%0d, required lk=1 code=80 v=1 hp=11",
                     bus.locked, bus.code_out, bus.code_valid, bus.half_period);
        else n_pass++;
        n_total++;
        if (strobe_cnt !== 4) $display("FAIL lock11_strobes: got %0d, required 4", strobe_cnt);
        else n_pass++;
        check_drained("lock11");
    endtask

    task automatic test_codes();
        toggle(4, 6);
        n_total++;
        if ({bus.locked, bus.code_out, bus.code_valid} !== {1'b1, 8'h01, 1'b1})
            $display("FAIL code4: got lk=%0b code=%h v=%0b, required lk=1 code=01 v=1",
                     bus.locked, bus.code_out, bus.code_valid);
        else n_pass++;
        toggle(51, 6);
        n_total++;
        if ({bus.locked, bus.code_out, bus.code_valid, bus.half_period} !== {1'b1, 8'h00, 1'b1, 8'd51})
            $display("FAIL code51: got lk=%0b code=%h v=%0b hp=%0d, required lk=1 code=00 v=1 hp=51",
                     bus.locked, bus.code_out, bus.code_valid, bus.half_period);
        else n_pass++;
        check_drained("codes");
    endtask

    task automatic test_relock();
        toggle(7, 6);
        n_total++;
        if ({bus.locked, bus.code_out} !== {1'b1, 8'h08})
            $display("FAIL lock7: got lk=%0b code=%h, required lk=1 code=08", bus.locked, bus.code_out);
        else n_pass++;
        toggle(9, 1);
        n_total++;
        if ({bus.locked, bus.code_valid} !== 2'b00)
            $display("FAIL unlock9: got lk=%0b v=%0b, required lk=0 v=0", bus.locked, bus.code_valid);
        else n_pass++;
        toggle(9, 2);
        n_total++;
        if (bus.locked !== 1'b0) $display("FAIL relock9_early: got locked=%0b, required 0", bus.locked);
        else n_pass++;
        toggle(9, 1);
        n_total++;
        if ({bus.locked, bus.code_out, bus.code_valid} !== {1'b1, 8'h20, 1'b1})
            $display("FAIL relock9: got lk=%0b code=%h v=%0b, required lk=1 code=20 v=1",
                     bus.locked, bus.code_out, bus.code_valid);
        else n_pass++;
        check_drained("relock");
    endtask

    task automatic test_timeout();
        toggle(7, 6);
        // Last edge is captured 3 cycles after the toggle; 4 cycles have elapsed.
        repeat (TMO - 2) @(posedge clk);
        #1;
        n_total++;
        if ({bus.lost, bus.locked} !== 2'b01)
            $display("FAIL timeout_early: got lost=%0b lk=%0b, required lost=0 lk=1", bus.lost, bus.locked);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({bus.lost, bus.locked, bus.code_valid, bus.half_period} !== {1'b1, 1'b0, 1'b0, 8'd7})
            $display("FAIL timeout: got lost=%0b lk=%0b v=%0b hp=%0d, required lost=1 lk=0 v=0 hp=7",
                     bus.lost, bus.locked, bus.code_valid, bus.half_period);
        else n_pass++;
        toggle(5, 1);
        n_total++;
        if ({bus.lost, bus.locked} !== 2'b00)
            $display("FAIL rearm: got lost=%0b lk=%0b, required lost=0 lk=0", bus.lost, bus.locked);
        else n_pass++;
        toggle(6, 1);
        repeat (TMO + 5) @(posedge clk);
        #1;
        n_total++;
        if (bus.lost !== 1'b1) $display("FAIL timeout2: got lost=%0b, required 1", bus.lost);
        else n_pass++;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        m_state = 0;
        m_match = 0;
        n_total++;
        if ({bus.lost, bus.locked} !== 2'b00)
            $display("FAIL clear: got lost=%0b lk=%0b, required lost=0 lk=0", bus.lost, bus.locked);
        else n_pass++;
        check_drained("timeout");
    endtask

    task automatic test_err();
        toggle(20, 6);
        n_total++;
        if ({bus.locked, bus.code_err, bus.code_valid, bus.code_out, bus.half_period} !==
            {1'b1, 1'b1, 1'b0, 8'h00, 8'd20})
            $display("FAIL err20: got lk=%0b e=%0b v=%0b code=%h hp=%0d, required lk=1 e=1 v=0 code=00 hp=20",
                     bus.locked, bus.code_err, bus.code_valid, bus.code_out, bus.half_period);
        else n_pass++;
        check_drained("err");
    endtask

    task automatic test_ena_hold();
        toggle(11, 6);
        bus.ena = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        n_total++;
        if ({bus.locked, bus.code_out, bus.code_valid, bus.half_period, bus.lost} !==
            {1'b1, 8'h80, 1'b1, 8'd11, 1'b0})
            $display("FAIL ena_hold: got lk=%0b code=%h v=%0b hp=%0d lost=%0b, required lk=1 code=80 v=1 hp=11 lost=0",
                     bus.locked, bus.code_out, bus.code_valid, bus.half_period, bus.lost);
        else n_pass++;
        bus.ena = 1'b1;
        // Interval spanning the hold must count only enabled cycles.
        toggle(11, 2);
        n_total++;
        if ({bus.locked, bus.half_period} !== {1'b1, 8'd11})
            $display("FAIL ena_resume: got lk=%0b hp=%0d, required lk=1 hp=11", bus.locked, bus.half_period);
        else n_pass++;
        check_drained("ena");
    endtask

    task automatic test_reset_mid();
        toggle(11, 2);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.half_period, bus.meas_strobe, bus.code_out, bus.code_valid, bus.code_err,
             bus.locked, bus.lost} !== 21'd0)
            $display("FAIL reset_mid: got hp=%0d code=%h lk=%0b v=%0b, required all 0",
                     bus.half_period, bus.code_out, bus.locked, bus.code_valid);
        else n_pass++;
        bus.sig_in = 1'b0;
        sb_q.delete();
        m_state = 0;
        m_match = 0;
        m_code = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        toggle(11, 4);
        n_total++;
        if (bus.locked !== 1'b0) $display("FAIL relock_rst_early: got locked=%0b, required 0", bus.locked);
        else n_pass++;
        toggle(11, 1);
        n_total++;
        if ({bus.locked, bus.code_out} !== {1'b1, 8'h80})
            $display("FAIL relock_rst: got lk=%0b code=%h, required lk=1 code=80", bus.locked, bus.code_out);
        else n_pass++;
        check_drained("reset_mid");
    endtask

    initial begin
        bus.ena = 1'b0;
        bus.clear = 1'b0;
        bus.sig_in = 1'b0;
        test_reset();
        test_lock_11();
        test_codes();
        test_relock();
        test_err();
        test_timeout();
        test_ena_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
